sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command/data port between two requesters.
  - LCD scan-out framebuffer reader (video, read-only, latency-critical).
  - Julia pixel compute writer (compute, write-only).
- Sits between both requesters and the SDRAM controller inside the julia top.
- Grants whole bursts, tracks data beats to detect burst end, and bounds compute starvation with a wait counter.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 32, data width (matches S_DQ).
- LEN_W, 3, burst length field width; burst beats = len+1 (1..8).
- STARVE_MAX, 64, compute wait cycles before compute gets one forced grant.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- vid_req  in  1  video burst request; held until vid_gnt.
- vid_addr  in  ADDR_W  video burst start address.
- vid_len  in  LEN_W  video burst beats-1.
- vid_gnt  out  1  one-cycle pulse: video command issued.
- vid_rdata  out  DATA_W  read data to video.
- vid_rvalid  out  1  vid_rdata valid.
- vid_done  out  1  one-cycle pulse with final video beat.
- cmp_req  in  1  compute burst request; held until cmp_gnt.
- cmp_addr  in  ADDR_W  compute burst start address.
- cmp_len  in  LEN_W  compute burst beats-1.
- cmp_wdata  in  DATA_W  compute write data.
- cmp_wready  out  1  cmp_wdata consumed this cycle.
- cmp_gnt  out  1  one-cycle pulse: compute command issued.
- cmp_done  out  1  one-cycle pulse with final compute beat.
- mem_cmd_valid  out  1  command valid to controller.
- mem_cmd_ready  in  1  controller accepts command.
- mem_cmd_we  out  1  1=write, 0=read.
- mem_cmd_addr  out  ADDR_W  command address.
- mem_cmd_len  out  LEN_W  command beats-1.
- mem_wdata  out  DATA_W  write data (combinational from cmp_wdata).
- mem_wready  in  1  controller takes write beat.
- mem_rdata  in  DATA_W  read data.
- mem_rvalid  in  1  read beat valid.
- owner  out  2  0=idle, 1=video, 2=compute (debug/LEDG).

Behaviour:
- Reset (rst_n low at a clk edge, any state):
  - State returns to IDLE; owner=0; beat counter=0; starve counter=0.
  - All outputs driven 0, including mem_cmd_* and all pulses.
  - An in-flight burst is abandoned; the controller is reset by the same rst_n.
- State IDLE:
  - Arbitration is registered; at most one command is issued per IDLE→CMD transition.
  - Video wins if vid_req=1, unless starve counter == STARVE_MAX and cmp_req=1; then compute wins.
  - Else compute wins if cmp_req=1; else stay in IDLE.
- State CMD (V_CMD or C_CMD):
  - Latch addr/len/we from the winner on entry. Assert mem_cmd_valid with latched values.
  - Hold until mem_cmd_ready=1. That cycle: pulse vid_gnt or cmp_gnt, then go to DATA.
- State V_DATA:
  - vid_rdata=mem_rdata and vid_rvalid=mem_rvalid, both combinational.
  - Count mem_rvalid beats. On beat number len+1: pulse vid_done in the same cycle, go to IDLE.
- State C_DATA:
  - cmp_wready=mem_wready and mem_wdata=cmp_wdata.
  - Count mem_wready beats; on the final beat pulse cmp_done and go to IDLE.
- Outside DATA:
  - vid_rvalid=0 and cmp_wready=0 regardless of mem_rvalid/mem_wready.
  - A stray mem_rvalid is ignored.
- Starve counter:
  - Increments each cycle cmp_req=1 and compute is not owner; saturates at STARVE_MAX.
  - Clears on cmp_gnt.
- Back-to-back bursts:
  - Minimum one IDLE cycle between bursts. With a command accepted immediately, burst N+1 command is valid 2 cycles after burst N done.
- Simultaneous requests, no starvation: video granted; compute waits.
- Simultaneous done and new request: the request is sampled in IDLE on the next cycle.
- Requester drops req before gnt: protocol violation. Once in CMD the latched command completes.
- len=0: single-beat burst, with done on the first beat.

Test Plan:
- Single video read: vid_req with addr=0x000100, len=7; controller ready immediately, 8 rvalid beats 0xA0..A7 → one vid_gnt, 8 vid_rvalid with matching data, vid_done on 8th beat, owner 1→0.
- Single compute write: cmp_req, addr=0x200000, len=3, wdata 0x11..0x14; mem_wready every other cycle → mem_cmd_we=1, mem_wdata matches each beat, cmp_done on 4th wready.
- Contention: vid_req and cmp_req rise same cycle, len=0 each → video command first; compute command follows 2 cycles after vid_done.
- Starvation: vid_req held high continuously, cmp_req high, STARVE_MAX=64 → compute granted after starve counter reaches 64; exactly one compute burst, then video resumes; counter back to 0.
- Backpressure: mem_cmd_ready low for 10 cycles → mem_cmd_valid/addr/len stable throughout, gnt only in the accept cycle.
- Reset mid-burst: rst_n low during V_DATA after beat 3 of 8 → next cycle owner=0, all outputs 0; after release, pending cmp_req is granted normally.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
//   Shares the single SDRAM controller command/data port between the LCD
//   scan-out reader (video, read-only, latency critical) and the Julia pixel
//   writer (compute, write-only). Whole bursts are granted; data beats are
//   counted to find the end of a burst. Video normally wins, but a compute
//   requester that has waited STARVE_MAX cycles gets one forced grant.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   vid_req/addr/len -> vid_gnt      video burst request / command-issued pulse
//   vid_rdata, vid_rvalid, vid_done  read data path to video, final-beat pulse
//   cmp_req/addr/len -> cmp_gnt      compute burst request / command-issued pulse
//   cmp_wdata, cmp_wready, cmp_done  write data path from compute, final-beat pulse
//   mem_cmd_*                        command channel to the SDRAM controller
//   mem_wdata, mem_wready            write beat channel
//   mem_rdata, mem_rvalid            read beat channel
//   owner                            0 idle, 1 video, 2 compute
module sdram_port_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 3,
  parameter int STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [LEN_W-1:0]  vid_len,
  output logic              vid_gnt,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_rvalid,
  output logic              vid_done,
  input  logic              cmp_req,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [LEN_W-1:0]  cmp_len,
  input  logic [DATA_W-1:0] cmp_wdata,
  output logic              cmp_wready,
  output logic              cmp_gnt,
  output logic              cmp_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [LEN_W-1:0]  mem_cmd_len,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [1:0]        owner
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, V_CMD, V_DATA, C_CMD, C_DATA} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              starve_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      starve_q <= starve_d;
    end
  end

  assign starve_full = (starve_q == SW'(STARVE_MAX));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    beat_d        = beat_q;
    starve_d      = starve_q;
    vid_gnt       = 1'b0;
    vid_rdata     = '0;
    vid_rvalid    = 1'b0;
    vid_done      = 1'b0;
    cmp_wready    = 1'b0;
    cmp_gnt       = 1'b0;
    cmp_done      = 1'b0;
    mem_cmd_valid = 1'b0;
    mem_cmd_we    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_len   = '0;
    mem_wdata     = '0;
    owner         = 2'd0;

    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        // Video has priority unless compute has waited out its full budget.
        if (vid_req && !(starve_full && cmp_req)) begin
          state_d = V_CMD;
          addr_d  = vid_addr;
          len_d   = vid_len;
        end else if (cmp_req) begin
          state_d = C_CMD;
          addr_d  = cmp_addr;
          len_d   = cmp_len;
        end
      end
      V_CMD: begin
        owner         = 2'd1;
        mem_cmd_valid = 1'b1;
        mem_cmd_addr  = addr_q;
        mem_cmd_len   = len_q;
        if (mem_cmd_ready) begin
          vid_gnt = 1'b1;
          state_d = V_DATA;
        end
      end
      C_CMD: begin
        owner         = 2'd2;
        mem_cmd_valid = 1'b1;
        mem_cmd_we    = 1'b1;
        mem_cmd_addr  = addr_q;
        mem_cmd_len   = len_q;
        if (mem_cmd_ready) begin
          cmp_gnt = 1'b1;
          state_d = C_DATA;
        end
      end
      V_DATA: begin
        owner      = 2'd1;
        vid_rdata  = mem_rdata;
        vid_rvalid = mem_rvalid;
        if (mem_rvalid) begin
          if (beat_q == len_q) begin
            vid_done = 1'b1;
            beat_d   = '0;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      C_DATA: begin
        owner      = 2'd2;
        mem_wdata  = cmp_wdata;
        cmp_wready = mem_wready;
        if (mem_wready) begin
          if (beat_q == len_q) begin
            cmp_done = 1'b1;
            beat_d   = '0;
            state_d  = IDLE;
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Wait budget only runs while compute is asking and does not hold the port.
    if (cmp_gnt)
      starve_d = '0;
    else if (cmp_req && owner != 2'd2 && !starve_full)
      starve_d = starve_q + SW'(1);
  end

endmodule
